// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: FSM state type, AXI response/burst encodings and response
// classification shared by apb2axi and its bench.
package apb2axi_pkg;
   typedef enum logic [2:0] {IDLE, WR_REQ, WAIT_B, RD_REQ, WAIT_R, RESP} state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   function automatic logic resp_err(input logic [1:0] r);
      return r == RESP_SLVERR || r == RESP_DECERR;
   endfunction
endpackage

// File: rtl/apb2axi.sv
// apb2axi: APB3/APB4 completer issuing one single-beat AXI4 transaction per transfer.
// Define APB2AXI_PSTRB_EN to add a PSTRB port driving WSTRB_o (otherwise all ones).
module apb2axi
   import apb2axi_pkg::*;
#(
   parameter int          AXI4_ADDRESS_WIDTH = 32,
   parameter int          AXI4_DATA_WIDTH    = 32,
   parameter int          AXI4_ID_WIDTH      = 16,
   parameter int unsigned AXI_ID             = 0,
   parameter int          APB_ADDR_WIDTH     = 32
) (
   input  logic                          ACLK,
   input  logic                          ARESETn,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   input  logic                          PWRITE,
   input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
   input  logic [AXI4_DATA_WIDTH-1:0]    PWDATA,
`ifdef APB2AXI_PSTRB_EN
   input  logic [AXI4_DATA_WIDTH/8-1:0]  PSTRB,
`endif
   output logic [AXI4_DATA_WIDTH-1:0]    PRDATA,
   output logic                          PREADY,
   output logic                          PSLVERR,
   output logic [AXI4_ID_WIDTH-1:0]      AWID_o,
   output logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_o,
   output logic [7:0]                    AWLEN_o,
   output logic [2:0]                    AWSIZE_o,
   output logic [1:0]                    AWBURST_o,
   output logic [2:0]                    AWPROT_o,
   output logic                          AWVALID_o,
   input  logic                          AWREADY_i,
   output logic [AXI4_DATA_WIDTH-1:0]    WDATA_o,
   output logic [AXI4_DATA_WIDTH/8-1:0]  WSTRB_o,
   output logic                          WLAST_o,
   output logic                          WVALID_o,
   input  logic                          WREADY_i,
   input  logic [AXI4_ID_WIDTH-1:0]      BID_i,
   input  logic [1:0]                    BRESP_i,
   input  logic                          BVALID_i,
   output logic                          BREADY_o,
   output logic [AXI4_ID_WIDTH-1:0]      ARID_o,
   output logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_o,
   output logic [7:0]                    ARLEN_o,
   output logic [2:0]                    ARSIZE_o,
   output logic [1:0]                    ARBURST_o,
   output logic [2:0]                    ARPROT_o,
   output logic                          ARVALID_o,
   input  logic                          ARREADY_i,
   input  logic [AXI4_ID_WIDTH-1:0]      RID_i,
   input  logic [AXI4_DATA_WIDTH-1:0]    RDATA_i,
   input  logic [1:0]                    RRESP_i,
   input  logic                          RLAST_i,
   input  logic                          RVALID_i,
   output logic                          RREADY_o
);
   state_t                        state;
   logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
   logic [AXI4_DATA_WIDTH-1:0]    wdata_q;
   logic                          aw_done, w_done, err;
   logic                          aw_next, w_next, both, start, unused;
   assign unused  = ^{BID_i, RID_i, RLAST_i};
   assign start   = state == IDLE && PSEL && PENABLE;
   assign aw_next = aw_done | (AWVALID_o & AWREADY_i);
   assign w_next  = w_done | (WVALID_o & WREADY_i);
   assign both    = aw_next & w_next;
   assign AWVALID_o = state == WR_REQ && !aw_done;
   assign WVALID_o  = state == WR_REQ && !w_done;
   assign ARVALID_o = state == RD_REQ;
   assign BREADY_o  = state == WAIT_B;
   assign RREADY_o  = state == WAIT_R;
   assign PREADY    = state == RESP;
   assign PSLVERR   = state == RESP && err;
   assign AWID_o    = AXI4_ID_WIDTH'(AXI_ID);
   assign ARID_o    = AXI4_ID_WIDTH'(AXI_ID);
   assign AWADDR_o  = addr_q;
   assign ARADDR_o  = addr_q;
   assign AWLEN_o   = '0;
   assign ARLEN_o   = '0;
   assign AWSIZE_o  = 3'($clog2(AXI4_DATA_WIDTH / 8));
   assign ARSIZE_o  = 3'($clog2(AXI4_DATA_WIDTH / 8));
   assign AWBURST_o = BURST_INCR;
   assign ARBURST_o = BURST_INCR;
   assign AWPROT_o  = '0;
   assign ARPROT_o  = '0;
   assign WDATA_o   = wdata_q;
   assign WLAST_o   = 1'b1;
`ifdef APB2AXI_PSTRB_EN
   logic [AXI4_DATA_WIDTH/8-1:0] wstrb_q;
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) wstrb_q <= '0;
      else if (start) wstrb_q <= PSTRB;
   assign WSTRB_o = wstrb_q;
`else
   assign WSTRB_o = '1;
`endif
   // AW and W complete independently; the sticky flags let either order finish
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         err     <= 1'b0;
         PRDATA  <= '0;
      end else
         case (state)
            IDLE: if (start) begin
               addr_q  <= AXI4_ADDRESS_WIDTH'(PADDR);
               wdata_q <= PWDATA;
               state   <= PWRITE ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
               aw_done <= aw_next & ~both;
               w_done  <= w_next & ~both;
               state   <= both ? WAIT_B : WR_REQ;
            end
            WAIT_B: if (BVALID_i) begin
               err   <= resp_err(BRESP_i);
               state <= RESP;
            end
            RD_REQ: if (ARREADY_i) state <= WAIT_R;
            WAIT_R: if (RVALID_i) begin
               PRDATA <= RDATA_i;
               err    <= resp_err(RRESP_i);
               state  <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_apb2axi.sv
// tb_apb2axi: directed APB transfers against a stall-programmable AXI responder.
module tb_apb2axi;
   import apb2axi_pkg::*;
   logic        ACLK = 1'b0, ARESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
`ifdef APB2AXI_PSTRB_EN
   logic [3:0]  PSTRB;
`endif
   logic [15:0] AWID_o, ARID_o, BID_i, RID_i;
   logic [31:0] AWADDR_o, ARADDR_o, WDATA_o, RDATA_i;
   logic [7:0]  AWLEN_o, ARLEN_o;
   logic [2:0]  AWSIZE_o, ARSIZE_o, AWPROT_o, ARPROT_o;
   logic [1:0]  AWBURST_o, ARBURST_o, BRESP_i, RRESP_i;
   logic [3:0]  WSTRB_o;
   logic        AWVALID_o, AWREADY_i, WLAST_o, WVALID_o, WREADY_i, BVALID_i, BREADY_o;
   logic        ARVALID_o, ARREADY_i, RLAST_i, RVALID_i, RREADY_o;
   int          n_chk = 0, n_fail = 0;
   int          lat, aw_beats, w_beats, ar_beats, stable_err, overlap;
   logic [31:0] s_prdata, s_awaddr, s_wdata, s_araddr, last_rd = 0;
   logic        s_slverr, s_wlast;
   logic [3:0]  s_wstrb;
   logic [7:0]  s_len;
   logic [2:0]  s_size, s_prot;
   logic [1:0]  s_burst;
   logic [15:0] s_id;

   apb2axi #(.AXI_ID(32'h2A)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB2AXI_PSTRB_EN
      .PSTRB(PSTRB),
`endif
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
      .AWBURST_o(AWBURST_o), .AWPROT_o(AWPROT_o), .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
      .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WVALID_o(WVALID_o), .WREADY_i(WREADY_i),
      .BID_i(BID_i), .BRESP_i(BRESP_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o),
      .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
      .ARBURST_o(ARBURST_o), .ARPROT_o(ARPROT_o), .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
      .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i), .RVALID_i(RVALID_i),
      .RREADY_o(RREADY_o)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_axi();
      AWREADY_i = 0; WREADY_i = 0; ARREADY_i = 0; BVALID_i = 0; RVALID_i = 0;
   endtask

   // One APB transfer; the responder stalls each ready/valid by the given cycle counts
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input int aw_st, input int w_st, input int ar_st, input int rsp_st,
                       input logic [1:0] rsp);
      int aw_n = 0, w_n = 0, ar_n = 0, rsp_n = 0;
      logic aw_p = 0, w_p = 0, ar_p = 0, ph, rsp_done = 0, done = 0;
      logic [31:0] aw_a = 0, w_d = 0, ar_a = 0;
      aw_beats = 0; w_beats = 0; ar_beats = 0; stable_err = 0; overlap = 0; lat = -1;
      BRESP_i = rsp; RRESP_i = rsp; RDATA_i = wr ? 32'hBAD0BAD0 : data;
      PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
      @(posedge ACLK); #1 PENABLE = 1;
      @(posedge ACLK); #1;
      for (int k = 1; k < 60 && !done; k++) begin
         ph = wr ? (aw_beats > 0 && w_beats > 0) : (ar_beats > 0);
         if (aw_p && (!AWVALID_o || AWADDR_o != aw_a)) stable_err++;
         if (w_p && (!WVALID_o || WDATA_o != w_d)) stable_err++;
         if (ar_p && (!ARVALID_o || ARADDR_o != ar_a)) stable_err++;
         if ((wr && (ARVALID_o || RREADY_o)) || (!wr && (AWVALID_o || WVALID_o || BREADY_o))) overlap++;
         AWREADY_i = AWVALID_o && aw_n >= aw_st;
         WREADY_i  = WVALID_o && w_n >= w_st;
         ARREADY_i = ARVALID_o && ar_n >= ar_st;
         BVALID_i  = wr && ph && !rsp_done && rsp_n >= rsp_st;
         RVALID_i  = !wr && ph && !rsp_done && rsp_n >= rsp_st;
         if (AWVALID_o && AWREADY_i) begin
            aw_beats++; s_awaddr = AWADDR_o; s_len = AWLEN_o; s_size = AWSIZE_o;
            s_burst = AWBURST_o; s_prot = AWPROT_o; s_id = AWID_o;
         end
         if (WVALID_o && WREADY_i) begin
            w_beats++; s_wdata = WDATA_o; s_wstrb = WSTRB_o; s_wlast = WLAST_o;
         end
         if (ARVALID_o && ARREADY_i) begin
            ar_beats++; s_araddr = ARADDR_o; s_len = ARLEN_o; s_size = ARSIZE_o;
            s_burst = ARBURST_o; s_prot = ARPROT_o; s_id = ARID_o;
         end
         if ((BVALID_i && BREADY_o) || (RVALID_i && RREADY_o)) rsp_done = 1;
         if (PREADY) begin
            done = 1; lat = k; s_prdata = PRDATA; s_slverr = PSLVERR;
         end
         aw_p = AWVALID_o && !AWREADY_i; aw_a = AWADDR_o;
         w_p  = WVALID_o && !WREADY_i;   w_d  = WDATA_o;
         ar_p = ARVALID_o && !ARREADY_i; ar_a = ARADDR_o;
         if (aw_p) aw_n++;
         if (w_p) w_n++;
         if (ar_p) ar_n++;
         if (ph) rsp_n++;
         @(posedge ACLK); #1;
      end
      PSEL = 0; PENABLE = 0;
      idle_axi();
   endtask

   task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int aw_st, input int w_st, input int ar_st, input int rsp_st,
                      input logic [1:0] rsp, input logic [3:0] strb);
      logic [3:0] exp_strb;
`ifdef APB2AXI_PSTRB_EN
      PSTRB = strb; exp_strb = strb;
`else
      exp_strb = 4'hF;
`endif
      xfer(wr, addr, data, aw_st, w_st, ar_st, rsp_st, rsp);
      if (!wr) last_rd = data;
      check("latency", lat, wr ? 3 + (aw_st > w_st ? aw_st : w_st) + rsp_st : 3 + ar_st + rsp_st);
      check("pslverr", 32'(s_slverr), 32'(rsp[1]));
      check("prdata", s_prdata, last_rd);
      check("pready_drop", 32'({PREADY, PSLVERR}), 0);
      check("valid_stable", stable_err, 0);
      check("chan_overlap", overlap, 0);
      check("len", 32'(s_len), 0);
      check("size", 32'(s_size), 2);
      check("burst", 32'(s_burst), 32'(BURST_INCR));
      check("prot", 32'(s_prot), 0);
      check("id", 32'(s_id), 32'h2A);
      if (wr) begin
         check("aw_beats", aw_beats, 1);
         check("w_beats", w_beats, 1);
         check("awaddr", s_awaddr, addr);
         check("wdata", s_wdata, data);
         check("wstrb", 32'(s_wstrb), 32'(exp_strb));
         check("wlast", 32'(s_wlast), 1);
      end else begin
         check("ar_beats", ar_beats, 1);
         check("araddr", s_araddr, addr);
      end
   endtask

   initial begin
      ARESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
`ifdef APB2AXI_PSTRB_EN
      PSTRB = 0;
`endif
      BID_i = 16'h1234; RID_i = 16'h4321; RLAST_i = 0; BRESP_i = 0; RRESP_i = 0; RDATA_i = 0;
      idle_axi();
      repeat (2) @(posedge ACLK);
      #1;
      check("rst_ctl", 32'({PREADY, PSLVERR, AWVALID_o, WVALID_o, ARVALID_o, BREADY_o, RREADY_o}), 0);
      check("rst_prdata", PRDATA, 0);
      ARESETn = 1;
      @(posedge ACLK); #1;
      run(1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, RESP_OKAY, 4'hF);
      run(1, 32'h104, 32'hCAFEF00D, 3, 0, 0, 0, RESP_OKAY, 4'h5);
      run(1, 32'h108, 32'h0BADC0DE, 0, 3, 0, 1, RESP_EXOKAY, 4'hF);
      run(0, 32'h200, 32'h12345678, 0, 0, 2, 0, RESP_SLVERR, 4'hF);
      run(1, 32'h10C, 32'h11112222, 0, 0, 0, 0, RESP_DECERR, 4'h0);
      run(1, 32'h400, 32'hA5A5A5A5, 2, 1, 0, 2, RESP_OKAY, 4'h3);
      run(0, 32'h404, 32'h5A5A5A5A, 0, 0, 1, 3, RESP_EXOKAY, 4'hF);
      run(1, 32'h408, 32'h01234567, 1, 2, 0, 1, RESP_SLVERR, 4'hC);
      run(0, 32'h40C, 32'h89ABCDEF, 0, 0, 3, 1, RESP_OKAY, 4'hF);
      // abort a write while it waits for its response
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h300; PWDATA = 32'h33333333;
      @(posedge ACLK); #1 PENABLE = 1;
      @(posedge ACLK); #1;
      AWREADY_i = 1; WREADY_i = 1;
      for (int i = 0; i < 10 && !BREADY_o; i++) begin
         @(posedge ACLK); #1;
      end
      check("rst_reach_wait_b", 32'(BREADY_o), 1);
      check("rst_pre_prdata", PRDATA, 32'h89ABCDEF);
      idle_axi();
      #2 ARESETn = 0;
      #1;
      check("rst_mid_ctl", 32'({PREADY, PSLVERR, AWVALID_o, WVALID_o, ARVALID_o, BREADY_o, RREADY_o}), 0);
      check("rst_mid_prdata", PRDATA, 0);
      last_rd = 0;
      @(posedge ACLK); #1;
      ARESETn = 1; PSEL = 0; PENABLE = 0;
      @(posedge ACLK); #1;
      run(0, 32'h500, 32'hFEEDFACE, 0, 0, 0, 0, RESP_OKAY, 4'hF);
      run(1, 32'h504, 32'h600DF00D, 1, 1, 0, 0, RESP_OKAY, 4'h9);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
